ra_to_dif: RTL and testbench

RA_TO_DIF -- requirements
Module: ra_to_dif

---
 rtl/ra_to_dif.sv | 92 +++++++++
 tb/tb_ra_to_dif.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_to_dif.sv
// rtl/ra_to_dif.sv - four-phase request/acknowledge producer into a valid/ready stream through a circular FIFO
module ra_to_dif #(
    parameter int DWd   = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ra_rdy,
    input  logic [DWd-1:0]           ra_data,
    output logic                     ra_ack,
    output logic [DWd-1:0]           dif_data,
    output logic                     dif_valid,
    input  logic                     dif_ready,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t          state_q, state_d;
    logic            ra_ack_q, ra_ack_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [DWd-1:0]  mem_q [DEPTH];
    logic            push, pop;

    always_comb begin
        // Space is judged on the pre-edge occupancy, so a same-cycle pop never frees room
        push     = (state_q == IDLE) && ra_rdy && (occ_q != FULL);
        pop      = (occ_q != '0) && dif_ready;
        state_d  = state_q;
        ra_ack_d = ra_ack_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        case (state_q)
            IDLE: if (push) begin
                state_d  = ACK;
                ra_ack_d = 1'b1;
            end
            ACK: if (!ra_rdy) begin
                state_d  = IDLE;
                ra_ack_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                ra_ack_d = 1'b0;
            end
        endcase

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ra_ack_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            ra_ack_q <= ra_ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ra_data;
    end

    assign ra_ack    = ra_ack_q;
    assign dif_valid = (occ_q != '0);
    assign dif_data  = mem_q[rd_ptr_q];
    assign occ       = occ_q;

endmodule

// File: tb/tb_ra_to_dif.sv
// tb/tb_ra_to_dif.sv - randomized self-checking bench for ra_to_dif against a queue model
module tb_ra_to_dif;

    localparam int DWd   = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             ra_rdy;
    logic [DWd-1:0]   ra_data;
    logic             ra_ack;
    logic [DWd-1:0]   dif_data;
    logic             dif_valid;
    logic             dif_ready;
    logic [2:0]       occ;

    int checks = 0;
    int errors = 0;
    int max_occ = 0;

    logic [DWd-1:0] q[$];
    logic [DWd-1:0] dut_out[$];
    bit             m_ack = 0;

    ra_to_dif #(.DWd(DWd), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ra_rdy(ra_rdy), .ra_data(ra_data),
        .ra_ack(ra_ack), .dif_data(dif_data), .dif_valid(dif_valid),
        .dif_ready(dif_ready), .occ(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock, step the model by the handshake rules, compare DUT to model.
    task automatic cycle();
        bit mpush, mpop;
        mpush = !m_ack && ra_rdy && (q.size() < DEPTH);
        mpop  = (q.size() > 0) && dif_ready;
        if (dif_valid && dif_ready) dut_out.push_back(dif_data);
        @(posedge clk);
        #1;
        if (mpop)  void'(q.pop_front());
        if (mpush) q.push_back(ra_data);
        m_ack = m_ack ? ra_rdy : mpush;
        if (int'(occ) > max_occ) max_occ = int'(occ);

        checks++;
        if (ra_ack !== m_ack) begin
            errors++; $display("FAIL model_ra_ack: got %b want %b at %0t", ra_ack, m_ack, $time);
        end
        checks++;
        if (occ !== 3'(q.size())) begin
            errors++; $display("FAIL model_occ: got %0d want %0d at %0t", occ, q.size(), $time);
        end
        checks++;
        if (dif_valid !== (q.size() > 0)) begin
            errors++; $display("FAIL model_dif_valid: got %b want %b at %0t", dif_valid, q.size() > 0, $time);
        end
        if (q.size() > 0) begin
            checks++;
            if (dif_data !== q[0]) begin
                errors++; $display("FAIL model_dif_data: got %h want %h at %0t", dif_data, q[0], $time);
            end
        end
    endtask

    task automatic handshake(input logic [DWd-1:0] d, input bit rnd_ready);
        int n;
        ra_data = d;
        ra_rdy  = 1'b1;
        n = 0;
        while (!ra_ack && n < 60) begin
            if (rnd_ready) dif_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        checks++;
        if (!ra_ack) begin
            errors++; $display("FAIL hs_ack_timeout: got ra_ack=%b want 1 data=%h", ra_ack, d);
        end
        ra_rdy = 1'b0;
        n = 0;
        while (ra_ack && n < 60) begin
            if (rnd_ready) dif_ready = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        checks++;
        if (ra_ack) begin
            errors++; $display("FAIL hs_release_timeout: got ra_ack=%b want 0", ra_ack);
        end
    endtask

    task automatic drain();
        int n;
        dif_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (occ !== 3'd0) begin
            errors++; $display("FAIL drain_empty: got occ=%0d want 0", occ);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ra_ack !== 1'b0 || dif_valid !== 1'b0 || occ !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got ack=%b valid=%b occ=%0d want 0 0 0", ra_ack, dif_valid, occ);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        dif_ready = 1'b1;
        ra_data   = 16'h1234;
        ra_rdy    = 1'b1;
        cycle();
        checks++;
        if (ra_ack !== 1'b1 || dif_valid !== 1'b1 || dif_data !== 16'h1234) begin
            errors++;
            $display("FAIL single_word: got ack=%b valid=%b data=%h want 1 1 1234", ra_ack, dif_valid, dif_data);
        end
        ra_rdy = 1'b0;
        cycle();
        checks++;
        if (ra_ack !== 1'b0 || occ !== 3'd0) begin
            errors++; $display("FAIL single_release: got ack=%b occ=%0d want 0 0", ra_ack, occ);
        end
    endtask

    task automatic test_fill();
        logic [DWd-1:0] exp[$];
        dut_out.delete();
        dif_ready = 1'b0;
        for (int k = 1; k <= 4; k++) handshake(DWd'(k), 1'b0);
        checks++;
        if (occ !== 3'd4) begin
            errors++; $display("FAIL fill_occ: got %0d want 4", occ);
        end
        ra_data = 16'd5;
        ra_rdy  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (ra_ack !== 1'b0) begin
                errors++; $display("FAIL full_hold_ack: got %b want 0", ra_ack);
            end
        end
        dif_ready = 1'b1;
        cycle();
        checks++;
        if (ra_ack !== 1'b0) begin
            errors++; $display("FAIL full_no_same_edge_push: got ack=%b want 0", ra_ack);
        end
        dif_ready = 1'b0;
        cycle();
        checks++;
        if (ra_ack !== 1'b1) begin
            errors++; $display("FAIL fifth_acked: got ack=%b want 1", ra_ack);
        end
        ra_rdy = 1'b0;
        cycle();
        drain();
        for (int k = 1; k <= 5; k++) exp.push_back(DWd'(k));
        checks++;
        if (dut_out != exp) begin
            errors++; $display("FAIL fill_order: got %0d words want 5 in order 1..5", dut_out.size());
        end
    endtask

    task automatic test_simultaneous();
        logic [DWd-1:0] w1, w2, w3;
        w1 = DWd'($urandom); w2 = DWd'($urandom); w3 = DWd'($urandom);
        dif_ready = 1'b0;
        handshake(w1, 1'b0);
        handshake(w2, 1'b0);
        dif_ready = 1'b1;
        ra_data   = w3;
        ra_rdy    = 1'b1;
        cycle();
        checks++;
        if (occ !== 3'd2 || dif_data !== w2 || ra_ack !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_same_edge: got occ=%0d data=%h ack=%b want 2 %h 1", occ, dif_data, ra_ack, w2);
        end
        ra_rdy = 1'b0;
        cycle();
        drain();
    endtask

    task automatic test_wrap();
        logic [DWd-1:0] exp[$];
        dut_out.delete();
        max_occ = 0;
        for (int i = 0; i < 10; i++) begin
            handshake(DWd'(16'hA0 + i), 1'b1);
            exp.push_back(DWd'(16'hA0 + i));
        end
        drain();
        checks++;
        if (dut_out != exp) begin
            errors++; $display("FAIL wrap_order: got %0d words want 10 in order A0..A9", dut_out.size());
        end
        checks++;
        if (max_occ > DEPTH) begin
            errors++; $display("FAIL wrap_max_occ: got %0d want <= %0d", max_occ, DEPTH);
        end
    endtask

    task automatic test_backpressure();
        logic [DWd-1:0] held;
        logic [2:0]     held_occ;
        dif_ready = 1'b0;
        handshake(DWd'($urandom), 1'b0);
        handshake(DWd'($urandom), 1'b0);
        held     = dif_data;
        held_occ = occ;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (dif_data !== held || occ !== held_occ || dif_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_stable: got data=%h occ=%0d want %h %0d", dif_data, occ, held, held_occ);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        logic [DWd-1:0] w;
        dif_ready = 1'b0;
        handshake(DWd'($urandom), 1'b0);
        handshake(DWd'($urandom), 1'b0);
        ra_data = DWd'($urandom);
        ra_rdy  = 1'b1;
        cycle();
        checks++;
        if (ra_ack !== 1'b1 || occ !== 3'd3) begin
            errors++; $display("FAIL pre_reset_state: got ack=%b occ=%0d want 1 3", ra_ack, occ);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ra_ack !== 1'b0 || dif_valid !== 1'b0 || occ !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got ack=%b valid=%b occ=%0d want 0 0 0", ra_ack, dif_valid, occ);
        end
        q.delete();
        m_ack  = 0;
        ra_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        dut_out.delete();
        w = DWd'($urandom);
        handshake(w, 1'b0);
        drain();
        checks++;
        if (dut_out.size() != 1 || dut_out[0] !== w) begin
            errors++; $display("FAIL post_reset_word: got %0d words want 1 word %h", dut_out.size(), w);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ra_rdy    = 1'b0;
        ra_data   = '0;
        dif_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_simultaneous();
        test_wrap();
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
